// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants, types and hex glyph table for the seven-segment scan controller.
package ssd_scan_controller_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Active-low cathodes ordered {a,b,c,d,e,f,g}; "b" and "d" are lowercase glyphs.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
      default: glyph = SEG_OFF;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/ssd_scan_controller_hex_seg_decoder.sv
// Combinational nibble to active-low seven-segment cathode decoder.
module hex_seg_decoder
  import ssd_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_glyph(nibble);

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit common-anode scan controller with frame-aligned value updates,
// per-slot blanking gap and leading-zero suppression.
//
// state    | meaning
// ST_BLANK | start of a digit slot, all anodes off to suppress ghosting
// ST_SHOW  | remainder of the slot, current digit driven (unless suppressed)
module ssd_scan_controller
  import ssd_scan_controller_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam scan_state_t   ST_START  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  logic [19:0]  disp;
  logic [19:0]  pend;
  logic         pend_full;
  digit_idx_t   digit;
  logic [CW-1:0] cnt;
  scan_state_t  state;
  scan_state_t  state_nxt;

  logic          slot_end;
  logic          boundary;
  logic          accept;
  logic          pend_full_nxt;
  logic [CW-1:0] cnt_nxt;
  digit_idx_t    digit_nxt;
  logic [3:0]    nibble;
  logic [3:0]    dp_bits;
  logic          lz_zero;
  logic          suppressed;
  logic [6:0]    glyph_seg;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  hex_seg_decoder u_dec (
    .nibble (nibble),
    .seg    (glyph_seg)
  );

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    boundary  = slot_end && (digit == 2'd3);
    cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
    digit_nxt = slot_end ? digit + 1'b1 : digit;
    state_nxt = (cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_SHOW;
  end

  // A transfer out of pend and a new capture are mutually exclusive: ready is low while full.
  always_comb begin
    accept        = value_valid && value_ready;
    pend_full_nxt = pend_full;
    if (boundary && pend_full) pend_full_nxt = 1'b0;
    else if (accept)           pend_full_nxt = 1'b1;
  end

  always_comb begin
    nibble  = disp[{digit, 2'b00} +: 4];
    dp_bits = disp[19:16];
    lz_zero = 1'b0;
    case (digit)
      2'd1:    lz_zero = (disp[15:4]  == 12'h000);
      2'd2:    lz_zero = (disp[15:8]  == 8'h00);
      2'd3:    lz_zero = (disp[15:12] == 4'h0);
      default: lz_zero = 1'b0;
    endcase
    suppressed = blank_lz && lz_zero;

    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state == ST_SHOW && !suppressed) begin
      an_nxt[digit] = 1'b0;
      seg_nxt       = glyph_seg;
      dp_nxt        = !dp_bits[digit];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_START;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      digit       <= '0;
      disp        <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      value_ready <= 1'b0;
      frame_done  <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      cnt         <= cnt_nxt;
      digit       <= digit_nxt;
      if (boundary && pend_full) disp <= pend;
      if (accept)                pend <= {dp_i, value_i};
      pend_full   <= pend_full_nxt;
      value_ready <= !pend_full_nxt;
      frame_done  <= boundary;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench: directed phases plus random traffic against a cycle-position reference model.
module tb_ssd_scan_controller;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = 16'h0;
  logic [3:0]  dp_i = 4'h0;
  logic        value_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        value_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  ssd_scan_controller #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_i     (value_i),
    .dp_i        (dp_i),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_done  (frame_done)
  );

  int passes = 0;
  int checks = 0;

  // Reference state: t = cycles elapsed since reset release, displayed word, one-entry pending slot.
  int          t = 0;
  logic [19:0] m_disp = '0;
  logic [19:0] m_pend = '0;
  bit          m_full = 0;
  bit          m_ready = 0;
  bit          last_accept = 0;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      default: lit = 7'b1000111;
    endcase
    return ~lit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
  endtask

  task automatic step();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    logic [15:0] v;
    int          d;
    int          off;
    bit          sup;
    bit          show;
    bit          bnd;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      m_disp = '0; m_pend = '0; m_full = 0; m_ready = 0; t = 0; last_accept = 0;
    end else begin
      d    = (t / DC) % 4;
      off  = t % DC;
      v    = m_disp[15:0];
      sup  = blank_lz && d >= 1 && ((v >> (4 * d)) == 16'h0);
      show = off >= BC && !sup;
      e_an  = show ? ~(4'b0001 << d) : 4'hF;
      e_seg = show ? glyph(v[4*d +: 4]) : 7'h7F;
      e_dp  = show ? ~m_disp[16+d] : 1'b1;
      bnd   = (t % FRAME) == FRAME - 1;
      e_fd  = bnd;
      last_accept = value_valid && m_ready;
      if (bnd && m_full) begin
        m_disp = m_pend; m_full = 0;
      end else if (last_accept) begin
        m_pend = {dp_i, value_i}; m_full = 1;
      end
      m_ready = !m_full;
      t++;
    end
    chk("an", {28'h0, an}, {28'h0, e_an});
    chk("seg", {25'h0, seg}, {25'h0, e_seg});
    chk("dp", {31'h0, dp}, {31'h0, e_dp});
    chk("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
    chk("value_ready", {31'h0, value_ready}, {31'h0, m_ready});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] p, input string tag);
    bit got;
    got = 0;
    value_i = v; dp_i = p; value_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = last_accept;
    end
    value_valid = 1'b0;
    chk(tag, {31'h0, got}, 32'h1);
  endtask

  initial begin
    int   last_fd;
    int   n_fd;
    logic fd_prev;
    bit   got;

    // Reset and idle
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME);

    // Scan pattern with a decimal point on digit 2
    offer(16'h1A3F, 4'b0100, "accept_1A3F");
    run(2 * FRAME + 5);

    // Backpressure: second offer held until the frame_done cycle
    offer(16'h1111, 4'b0000, "accept_1111");
    value_i = 16'h2222; dp_i = 4'b0011; value_valid = 1'b1;
    got = 0; fd_prev = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      fd_prev = frame_done;
      step();
      got = last_accept;
    end
    value_valid = 1'b0;
    chk("accept_2222", {31'h0, got}, 32'h1);
    chk("bp_accept_on_frame_done", {31'h0, fd_prev}, 32'h1);
    run(3 * FRAME);

    // Leading-zero suppression on and off
    blank_lz = 1'b1;
    offer(16'h0040, 4'b0001, "accept_0040");
    run(2 * FRAME + 3);
    blank_lz = 1'b0;
    run(FRAME + 3);
    blank_lz = 1'b1;
    offer(16'h0000, 4'b1111, "accept_0000");
    run(2 * FRAME);

    // Random traffic with live leading-zero toggling
    for (int k = 0; k < 14; k++) begin
      value_i     = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h00FF);
      dp_i        = 4'($urandom);
      blank_lz    = 1'($urandom);
      value_valid = 1'($urandom);
      run($urandom_range(5, 40));
    end
    value_valid = 1'b0;

    // Reset while digit 2 is shown and pend is occupied
    blank_lz = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = !m_full && (t % FRAME) == 1;
    end
    chk("drain_pending", {31'h0, got}, 32'h1);
    offer(16'hBEEF, 4'b1111, "accept_BEEF");
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = (t % FRAME) == 2 * DC + 4;
    end
    chk("reach_digit2_show", {31'h0, got}, 32'h1);
    chk("pend_occupied_before_reset", {31'h0, value_ready}, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(3 * FRAME);

    // Frame timing across 10 frames
    last_fd = -1; n_fd = 0;
    for (int i = 0; i < 11 * FRAME; i++) begin
      step();
      if (frame_done) begin
        if (last_fd >= 0) chk("frame_gap", i - last_fd, FRAME);
        last_fd = i;
        n_fd++;
      end
    end
    chk("frame_count", n_fd, 11);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
